// File: rtl/rv32i_core_pkg.sv
// rv32i_core_pkg: shared data-memory response type, latency bound and byte-merge helper
// Contents: DMEM_MAX_READ_LATENCY, dmem_rsp_t {valid, data}, dmem_apply_be(old_word, wdata, be)
package rv32i_core_pkg;
   localparam int DMEM_MAX_READ_LATENCY = 4;

   typedef struct packed {
      logic        valid;
      logic [31:0] data;
   } dmem_rsp_t;

   function automatic logic [31:0] dmem_apply_be(input logic [31:0] old_word, input logic [31:0] wdata,
                                                 input logic [3:0] be);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old_word[8*i +: 8];
      return r;
   endfunction
endpackage

// File: rtl/rv32i_dmem_delay_line.sv
// rv32i_dmem_delay_line: DEPTH-stage shift register of load responses
// Ports: clk_i, rst_i (sync, active-high), din (response entering stage 0), dout (last stage)
module rv32i_dmem_delay_line
   import rv32i_core_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  dmem_rsp_t din,
   output dmem_rsp_t dout
);
   dmem_rsp_t q [DEPTH];

   // Data only advances alongside a valid, so the last stage holds its word between responses.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      end else begin
         q[0].valid <= din.valid;
         if (din.valid) q[0].data <= din.data;
         for (int i = 1; i < DEPTH; i++) begin
            q[i].valid <= q[i-1].valid;
            if (q[i-1].valid) q[i].data <= q[i-1].data;
         end
      end
   end

   assign dout = q[DEPTH-1];
endmodule

// File: rtl/rv32i_dmem_responder.sv
// rv32i_dmem_responder: single-port data memory target for the rv32i MEM-stage load/store bus
module rv32i_dmem_responder
  import rv32i_core_pkg::*;
#(
  parameter int    DEPTH_WORDS  = 4096,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = ""
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        err_o,
  output logic [31:0] err_addr_o,
  input  logic        cnt_clr_i,
  output logic [31:0] load_cnt_o,
  output logic [31:0] store_cnt_o
);
  localparam int AW = $clog2(DEPTH_WORDS);
  if (READ_LATENCY < 1 || READ_LATENCY > DMEM_MAX_READ_LATENCY) begin : g_bad_latency
    $error("READ_LATENCY must be in 1..%0d", DMEM_MAX_READ_LATENCY);
  end
  logic [31:0] mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic in_range, ld, st;
  dmem_rsp_t rsp_in, rsp_out;
  assign idx      = data_addr_i[AW+1:2];
  assign in_range = data_addr_i[31:AW+2] == '0;
  assign ld       = data_req_i & ~data_we_i;
  assign st       = data_req_i & data_we_i;
  assign rsp_in   = '{valid: ld, data: in_range ? mem[idx] : '0};
  always_ff @(posedge clk_i) begin
    if (!rst_i && st && in_range) mem[idx] <= dmem_apply_be(mem[idx], data_wdata_i, data_be_i);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_o      <= 1'b0;
      err_addr_o <= '0;
    end else if (data_req_i && !in_range) begin
      err_o <= 1'b1;
      if (!err_o) err_addr_o <= data_addr_i;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i || cnt_clr_i) begin
      load_cnt_o  <= '0;
      store_cnt_o <= '0;
    end else begin
      if (ld && load_cnt_o != '1) load_cnt_o <= load_cnt_o + 32'd1;
      if (st && store_cnt_o != '1) store_cnt_o <= store_cnt_o + 32'd1;
    end
  end
  rv32i_dmem_delay_line #(.DEPTH(READ_LATENCY)) u_delay (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .din   (rsp_in),
    .dout  (rsp_out)
  );
  assign data_rvalid_o = rsp_out.valid;
  assign data_rdata_o  = rsp_out.data;
endmodule
